// File: rtl/riscv_core_rob_ctrl_pkg.sv
// Shared ROB geometry for the riscvooo core: reorder buffer depth, slot index
// width and architectural register index width. Imported by the ROB
// controller, and intended for the scoreboard and the ROB data array.
package riscv_core_rob_ctrl_pkg;

  localparam int unsigned ROB_ENTRIES_DFLT = 16;
  localparam int unsigned ROB_SLOT_W_DFLT  = $clog2(ROB_ENTRIES_DFLT);
  localparam int unsigned ROB_REG_W_DFLT   = 5;

endpackage

// File: rtl/riscv_core_rob_ctrl.sv
// In-order-commit reorder buffer controller.
// Decode allocates the tail slot, and writeback clears that slot's pending
// bit. The head slot retires once it is valid and no longer pending. Each
// cycle allows at most one alloc, one fill and one commit.
module riscv_core_rob_ctrl
  import riscv_core_rob_ctrl_pkg::*;
#(
  parameter int unsigned ROB_ENTRIES = ROB_ENTRIES_DFLT,
  parameter int unsigned SLOT_W      = ROB_SLOT_W_DFLT,
  parameter int unsigned REG_W       = ROB_REG_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rob_alloc_req_val,
  output logic              rob_alloc_req_rdy,
  input  logic              rob_alloc_req_wen,
  input  logic [REG_W-1:0]  rob_alloc_req_preg,
  output logic [SLOT_W-1:0] rob_alloc_resp_slot,
  input  logic              rob_fill_val,
  input  logic [SLOT_W-1:0] rob_fill_slot,
  output logic              rob_commit_val,
  output logic              rob_commit_wen,
  output logic [SLOT_W-1:0] rob_commit_slot,
  output logic [REG_W-1:0]  rob_commit_rf_waddr,
  output logic [SLOT_W:0]   rob_count
);

  localparam logic [SLOT_W:0] FULL_CNT = (SLOT_W+1)'(ROB_ENTRIES);

  logic [SLOT_W-1:0]      head_q, head_d;
  logic [SLOT_W-1:0]      tail_q, tail_d;
  logic [SLOT_W:0]        count_q, count_d;

  logic [ROB_ENTRIES-1:0] valid_vec;
  logic [ROB_ENTRIES-1:0] pending_vec;
  logic [ROB_ENTRIES-1:0] wen_vec;
  logic [REG_W-1:0]       preg_vec [ROB_ENTRIES];

  logic                   alloc_fire;
  logic                   commit_fire;

  // Readiness depends only on the registered count. A full ROB refuses
  // allocation even when the head retires in the same cycle.
  assign rob_alloc_req_rdy   = (count_q != FULL_CNT);
  assign rob_alloc_resp_slot = tail_q;
  assign alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;

  // Commit uses only registered slot state, so a fill becomes visible one
  // cycle after writeback. Commit is suppressed while reset is asserted.
  assign commit_fire = !reset && valid_vec[head_q] && !pending_vec[head_q];

  assign rob_commit_val      = commit_fire;
  assign rob_commit_wen      = commit_fire && wen_vec[head_q];
  assign rob_commit_slot     = head_q;
  assign rob_commit_rf_waddr = preg_vec[head_q];
  assign rob_count           = count_q;

  // Per-slot state. Alloc only ever targets a non-valid slot, so it never
  // collides with a fill or a commit on the same slot.
  for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_slot
    localparam logic [SLOT_W-1:0] IDX = SLOT_W'(i);

    logic             valid_q;
    logic             pending_q;
    logic             wen_q;
    logic [REG_W-1:0] preg_q;
    logic             alloc_here;
    logic             fill_here;
    logic             commit_here;

    assign alloc_here  = alloc_fire && (tail_q == IDX);
    // Fills to slots that are not in flight are dropped.
    assign fill_here   = rob_fill_val && (rob_fill_slot == IDX) && valid_q && pending_q;
    assign commit_here = commit_fire && (head_q == IDX);

    // Slot flops: alloc installs the entry, fill clears pending, and
    // commit frees the slot.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q   <= 1'b0;
        pending_q <= 1'b0;
        wen_q     <= 1'b0;
        preg_q    <= '0;
      end else if (alloc_here) begin
        valid_q   <= 1'b1;
        pending_q <= 1'b1;
        wen_q     <= rob_alloc_req_wen;
        preg_q    <= rob_alloc_req_preg;
      end else begin
        if (fill_here) begin
          pending_q <= 1'b0;
        end
        if (commit_here) begin
          valid_q <= 1'b0;
        end
      end
    end

    assign valid_vec[i]   = valid_q;
    assign pending_vec[i] = pending_q;
    assign wen_vec[i]     = wen_q;
    assign preg_vec[i]    = preg_q;
  end

  // Next-state pointers and occupancy. The pointers wrap naturally, and the
  // count separates a full ROB from an empty one.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc_fire) begin
      tail_d = tail_q + SLOT_W'(1);
    end
    if (commit_fire) begin
      head_d = head_q + SLOT_W'(1);
    end
    if (alloc_fire && !commit_fire) begin
      count_d = count_q + (SLOT_W+1)'(1);
    end else if (!alloc_fire && commit_fire) begin
      count_d = count_q - (SLOT_W+1)'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_rob_ctrl.sv
// Self-checking bench for riscv_core_rob_ctrl. A queue of in-flight
// instructions, kept in program order, predicts every output each cycle.
// Directed scenarios run first, followed by randomized traffic.
module tb_riscv_core_rob_ctrl;

  localparam int N      = 16;
  localparam int SLOT_W = 4;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rob_alloc_req_val = 1'b0;
  logic              rob_alloc_req_rdy;
  logic              rob_alloc_req_wen = 1'b0;
  logic [REG_W-1:0]  rob_alloc_req_preg = '0;
  logic [SLOT_W-1:0] rob_alloc_resp_slot;
  logic              rob_fill_val = 1'b0;
  logic [SLOT_W-1:0] rob_fill_slot = '0;
  logic              rob_commit_val;
  logic              rob_commit_wen;
  logic [SLOT_W-1:0] rob_commit_slot;
  logic [REG_W-1:0]  rob_commit_rf_waddr;
  logic [SLOT_W:0]   rob_count;

  always #5 clk = ~clk;

  riscv_core_rob_ctrl #(
    .ROB_ENTRIES(N),
    .SLOT_W     (SLOT_W),
    .REG_W      (REG_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .rob_alloc_req_val   (rob_alloc_req_val),
    .rob_alloc_req_rdy   (rob_alloc_req_rdy),
    .rob_alloc_req_wen   (rob_alloc_req_wen),
    .rob_alloc_req_preg  (rob_alloc_req_preg),
    .rob_alloc_resp_slot (rob_alloc_resp_slot),
    .rob_fill_val        (rob_fill_val),
    .rob_fill_slot       (rob_fill_slot),
    .rob_commit_val      (rob_commit_val),
    .rob_commit_wen      (rob_commit_wen),
    .rob_commit_slot     (rob_commit_slot),
    .rob_commit_rf_waddr (rob_commit_rf_waddr),
    .rob_count           (rob_count)
  );

  typedef struct {
    int slot;
    bit wen;
    int preg;
    bit filled;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  int   m_tail = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive the inputs, compare the outputs against the model,
  // then advance the model to account for the coming posedge.
  task automatic step(input bit rst, input bit val, input bit wen, input int preg,
                      input bit fv, input int fs);
    bit   exp_cv;
    bit   alloc_ok;
    bit   found;
    ent_t e;
    @(negedge clk);
    reset              = rst;
    rob_alloc_req_val  = val;
    rob_alloc_req_wen  = wen;
    rob_alloc_req_preg = REG_W'(preg);
    rob_fill_val       = fv;
    rob_fill_slot      = SLOT_W'(fs);
    #1;
    exp_cv = !rst && (q.size() > 0) && q[0].filled;
    check("count",       32'(rob_count),           32'(q.size()));
    check("rdy",         32'(rob_alloc_req_rdy),   32'(q.size() != N));
    check("resp_slot",   32'(rob_alloc_resp_slot), 32'(m_tail));
    check("commit_val",  32'(rob_commit_val),      32'(exp_cv));
    check("commit_wen",  32'(rob_commit_wen),      32'(exp_cv && q[0].wen));
    check("commit_slot", 32'(rob_commit_slot),     32'(m_head));
    if (exp_cv) begin
      check("commit_waddr", 32'(rob_commit_rf_waddr), 32'(q[0].preg));
    end
    if (rst) begin
      q.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      alloc_ok = val && (q.size() != N);
      if (fv) begin
        found = 1'b0;
        foreach (q[k]) begin
          if (q[k].slot == fs && !q[k].filled) begin
            q[k].filled = 1'b1;
            found = 1'b1;
          end
        end
        if (!found) begin
          errors++;
          $display("FAIL fill_target: slot %0d is not pending at %0t", fs, $time);
        end
      end
      if (exp_cv) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % N;
      end
      if (alloc_ok) begin
        e.slot   = m_tail;
        e.wen    = wen;
        e.preg   = preg;
        e.filled = 1'b0;
        q.push_back(e);
        m_tail = (m_tail + 1) % N;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int pend[$];
    int alloc_pct;
    int fill_pct;
    int pick;

    // Reset, then ten idle cycles.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(10);

    // Single instruction: alloc, fill, and commit two cycles later.
    step(0, 1, 1, 5, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2);

    // Fill the ROB, present a 17th request, then free the head while
    // allocation is held high.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, i[0], i + 3, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 30, 0, 0);
    step(0, 1, 0, 31, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Out-of-order fills still commit in order.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 10, 0, 0);
    step(0, 1, 1, 11, 0, 0);
    step(0, 1, 1, 12, 0, 0);
    step(0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    idle(4);

    // No-writeback instruction.
    step(0, 1, 0, 9, 0, 0);
    step(0, 0, 0, 0, 1, 3);
    idle(2);

    // Reset with eight in flight, some of them already filled.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, i + 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    idle(6);

    // Randomized traffic that alternates between filling and draining phases.
    for (int c = 0; c < 3000; c++) begin
      alloc_pct = ((c / 150) % 2 == 0) ? 85 : 35;
      fill_pct  = ((c / 150) % 2 == 0) ? 30 : 80;
      pend.delete();
      foreach (q[k]) if (!q[k].filled) pend.push_back(q[k].slot);
      if (pend.size() > 0 && $urandom_range(0, 99) < fill_pct) begin
        pick = pend[$urandom_range(0, pend.size() - 1)];
        step($urandom_range(0, 399) == 0, $urandom_range(0, 99) < alloc_pct,
             1'($urandom), int'($urandom_range(0, 31)), 1, pick);
      end else begin
        step($urandom_range(0, 399) == 0, $urandom_range(0, 99) < alloc_pct,
             1'($urandom), int'($urandom_range(0, 31)), 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
